// File: rtl/mult_share_sequencer_if.sv
// Requester/result bundle for the shared sequential multiplier.
// Both requesters and the result port share one interface.
interface mult_share_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_operand1;
  logic [WIDTH-1:0] req0_operand2;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_operand1;
  logic [WIDTH-1:0] req1_operand2;
  logic             req1_ready;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             result_id;
  logic             busy;

  modport master (
    output req0_valid, req0_operand1, req0_operand2,
    output req1_valid, req1_operand1, req1_operand2,
    input  req0_ready, req1_ready, result, result_valid, result_id, busy
  );

  modport slave (
    input  req0_valid, req0_operand1, req0_operand2,
    input  req1_valid, req1_operand1, req1_operand2,
    output req0_ready, req1_ready, result, result_valid, result_id, busy
  );
endinterface

// File: rtl/mult_share_sequencer.sv
// Two-requester shared multiplier: round-robin (or fixed) grant, then
// WIDTH-cycle shift-add producing the low WIDTH bits of the product.
module mult_share_sequencer #(
  parameter int WIDTH       = 8,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input logic clk,
  input logic rst,
  mult_share_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
  logic [CW-1:0]    count_q;
  logic             owner_q, last_grant_q, result_id_q;
  logic             winner, take, iter_done;

  // Winner is 1 only when REQ1 is valid and REQ0 either is absent or loses the round-robin.
  assign winner    = bus.req1_valid &
                     (~bus.req0_valid | (ROUND_ROBIN ? ~last_grant_q : 1'b0));
  assign take      = (state_q == IDLE) & (bus.req0_valid | bus.req1_valid) & ~rst;
  // RUN holds one extra cycle after the last iteration so that a handshake at
  // edge t yields RESULT_VALID at edge t+WIDTH+1.
  assign iter_done = (count_q == CW'(WIDTH));

  assign bus.req0_ready   = take & ~winner;
  assign bus.req1_ready   = take & winner;
  assign bus.busy         = (state_q != IDLE);
  assign bus.result_valid = (state_q == DONE);
  assign bus.result       = result_q;
  assign bus.result_id    = result_id_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = RUN;
      RUN:     if (iter_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      count_q      <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
      result_id_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (take) begin
          a_q          <= winner ? bus.req1_operand1 : bus.req0_operand1;
          b_q          <= winner ? bus.req1_operand2 : bus.req0_operand2;
          acc_q        <= '0;
          count_q      <= '0;
          owner_q      <= winner;
          last_grant_q <= winner;
        end
        RUN: if (!iter_done) begin
          if (b_q[0]) acc_q <= acc_q + a_q;
          a_q     <= a_q << 1;
          b_q     <= b_q >> 1;
          count_q <= count_q + CW'(1);
        end else begin
          result_q    <= acc_q;
          result_id_q <= owner_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_share_sequencer.sv
// Scoreboard bench for mult_share_sequencer: stimulus pushes expected results,
// a negedge monitor pops and compares value, owner and arrival cycle.
module tb_mult_share_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_share_sequencer_if #(.WIDTH(8)) bus();
  mult_share_sequencer_if #(.WIDTH(8)) fp_bus();

  assign fp_bus.req0_valid    = bus.req0_valid;
  assign fp_bus.req0_operand1 = bus.req0_operand1;
  assign fp_bus.req0_operand2 = bus.req0_operand2;
  assign fp_bus.req1_valid    = bus.req1_valid;
  assign fp_bus.req1_operand1 = bus.req1_operand1;
  assign fp_bus.req1_operand2 = bus.req1_operand2;

  mult_share_sequencer #(.WIDTH(8), .ROUND_ROBIN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  mult_share_sequencer #(.WIDTH(8), .ROUND_ROBIN(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(fp_bus));

  typedef struct {
    logic       id;
    logic [7:0] res;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   fp_seen = 0;
  bit   t4 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one pop per RESULT_VALID cycle; a pulse with nothing expected is an error.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.result_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %0h id %0d want none (cycle %0d)",
                 bus.result, bus.result_id, cyc);
      end else begin
        e = sb.pop_front();
        check("result", {24'd0, bus.result}, {24'd0, e.res});
        check("result_id", {31'd0, bus.result_id}, {31'd0, e.id});
        check("latency", cyc, e.cyc);
      end
    end
    if (t4 && !rst && fp_bus.result_valid) begin
      fp_seen++;
      check("fp_result_id", {31'd0, fp_bus.result_id}, 32'd0);
      check("fp_result", {24'd0, fp_bus.result}, 32'h06);
    end
  end

  task automatic issue(input bit id, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp, input bit push);
    bit got;
    got = 1'b0;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_operand1 = a; bus.req1_operand2 = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_operand1 = a; bus.req0_operand2 = b;
    end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) got = 1'b1;
    end
    check("handshake", {31'd0, got}, 32'd1);
    if (got && push) sb.push_back('{id, exp, cyc + 10});
    @(posedge clk); #1;
    if (id) bus.req1_valid = 1'b0;
    else    bus.req0_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("drain", sb.size(), 0);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
  endtask

  logic       tbl_id  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] tbl_res [4] = '{8'h06, 8'h14, 8'h06, 8'h14};

  initial begin
    int hs;
    bus.req0_valid = 1'b0; bus.req0_operand1 = '0; bus.req0_operand2 = '0;
    bus.req1_valid = 1'b0; bus.req1_operand1 = '0; bus.req1_operand2 = '0;

    // Reset state, with a requester valid to show READY is held low.
    #12;
    bus.req0_valid = 1'b1;
    #1;
    check("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_result_valid", {31'd0, bus.result_valid}, 32'd0);
    check("rst_result", {24'd0, bus.result}, 32'd0);
    check("rst_result_id", {31'd0, bus.result_id}, 32'd0);
    bus.req0_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Single op and boundary products.
    issue(1'b0, 8'hB5, 8'hC1, 8'h75, 1'b1); drain();
    issue(1'b0, 8'hFF, 8'hFF, 8'h01, 1'b1); drain();
    issue(1'b0, 8'h00, 8'hAB, 8'h00, 1'b1); drain();
    issue(1'b1, 8'h80, 8'h02, 8'h00, 1'b1); drain();
    issue(1'b0, 8'h03, 8'h05, 8'h0F, 1'b1); drain();

    // Abort: async reset mid-cycle, 4 cycles into RUN.
    issue(1'b1, 8'h11, 8'h22, 8'h00, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    bus.req0_valid = 1'b1;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_result_valid", {31'd0, bus.result_valid}, 32'd0);
    check("abort_result", {24'd0, bus.result}, 32'd0);
    check("abort_result_id", {31'd0, bus.result_id}, 32'd0);
    check("abort_ready0", {31'd0, bus.req0_ready}, 32'd0);
    bus.req0_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("post_abort_busy", {31'd0, bus.busy}, 32'd0);
    issue(1'b0, 8'h07, 8'h09, 8'h3F, 1'b1); drain();

    // Contention after reset: REQ0 first, then alternate; fixed-priority copy always REQ0.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    bus.req0_operand1 = 8'h02; bus.req0_operand2 = 8'h03;
    bus.req1_operand1 = 8'h04; bus.req1_operand2 = 8'h05;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    t4 = 1'b1;
    hs = 0;
    for (int i = 0; i < 100 && hs < 4; i++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin
        if (hs == 0) check("first_contest_ready0", {31'd0, bus.req0_ready}, 32'd1);
        check("grant_id", {31'd0, bus.req1_ready}, {31'd0, tbl_id[hs]});
        check("grant_onehot", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
        sb.push_back('{tbl_id[hs], tbl_res[hs], cyc + 10});
        hs++;
        if (hs == 4) begin
          @(posedge clk); #1;
          bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        end
      end
    end
    check("contention_handshakes", hs, 4);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    drain();
    t4 = 1'b0;
    check("fp_ops", fp_seen, 4);

    // Operand hold: operands change and VALID drops while RUN is in progress.
    bus.req1_valid = 1'b1; bus.req1_operand1 = 8'h0D; bus.req1_operand2 = 8'h0B;
    hs = 0;
    for (int i = 0; i < 50 && hs == 0; i++) begin
      @(negedge clk);
      if (bus.req1_ready) hs = 1;
    end
    check("hold_handshake", hs, 1);
    if (hs == 1) sb.push_back('{1'b1, 8'h8F, cyc + 10});
    @(posedge clk); #1;
    bus.req1_operand1 = 8'hFF; bus.req1_operand2 = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_ready1", {31'd0, bus.req1_ready}, 32'd0);
      check("hold_ready0", {31'd0, bus.req0_ready}, 32'd0);
    end
    @(posedge clk); #1 bus.req1_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
